vga_note_display: RTL and testbench

//  Parametrised VGA raster generator with per-note key overlay for the synth front panel.

---
 rtl/vga_note_pkg.sv | 43 ++++
 rtl/vga_timing_gen.sv | 72 +++++++
 rtl/vga_note_display.sv | 233 +++++++++++++++++++++++
 tb/tb_vga_note_display.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_note_pkg.sv
// Shared timing defaults, colour types and helpers for the note-overlay VGA display.
package vga_note_pkg;

    // Default 640x480@60 timing (25 MHz pixel clock from 50 MHz).
    localparam int DEF_NUM_NOTES   = 18;
    localparam int DEF_CLK_DIV     = 2;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_KEY_X0      = 8;
    localparam int DEF_KEY_Y0      = 400;
    localparam int DEF_KEY_W       = 32;
    localparam int DEF_KEY_GAP     = 3;
    localparam int DEF_KEY_H       = 64;
    localparam int DEF_FADE_FRAMES = 4;

    // Derived defaults: a line/frame is sync, back porch, active, front porch.
    localparam int DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam logic [3:0] GREY_LVL  = 4'h4;
    localparam rgb_t       RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t       RGB_GREY  = '{r: GREY_LVL, g: GREY_LVL, b: GREY_LVL};

    // Counter width that stays legal (>= 1 bit) for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and combinational sync/active/frame-start decode; advances on pe only.
module vga_timing_gen
    import vga_note_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b1,
    parameter int   HW          = $clog2(H_SYNC + H_BP + H_ACTIVE + H_FP),
    parameter int   VW          = $clog2(V_SYNC + V_BP + V_ACTIVE + V_FP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pe_i,
    output logic [HW-1:0] x_o,
    output logic [VW-1:0] y_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          active_o,
    output logic          frame_start_o
);

    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;

    // Next raster position: x wraps at H_TOTAL-1, y steps on x wrap and wraps at V_TOTAL-1.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pe_i) begin
            if (x_q == HW'(H_TOTAL - 1)) begin
                x_d = '0;
                if (y_q == VW'(V_TOTAL - 1)) y_d = '0;
                else                         y_d = y_q + VW'(1);
            end else begin
                x_d = x_q + HW'(1);
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign hsync_o       = (int'(x_q) < H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync_o       = (int'(y_q) < V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign active_o      = (int'(x_q) >= H_ACT_START) && (int'(x_q) < H_ACT_END) &&
                           (int'(y_q) >= V_ACT_START) && (int'(y_q) < V_ACT_END);
    assign frame_start_o = pe_i && (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/vga_note_display.sv
// VGA raster with a row of per-note key boxes: held notes show full red, released ones fade.
module vga_note_display
    import vga_note_pkg::*;
#(
    parameter int   NUM_NOTES   = DEF_NUM_NOTES,
    parameter int   CLK_DIV     = DEF_CLK_DIV,
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b1,
    parameter int   KEY_X0      = DEF_KEY_X0,
    parameter int   KEY_Y0      = DEF_KEY_Y0,
    parameter int   KEY_W       = DEF_KEY_W,
    parameter int   KEY_GAP     = DEF_KEY_GAP,
    parameter int   KEY_H       = DEF_KEY_H,
    parameter int   FADE_FRAMES = DEF_FADE_FRAMES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_NOTES-1:0] note,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic [3:0]           o_red,
    output logic [3:0]           o_green,
    output logic [3:0]           o_blue,
    output logic                 o_active,
    output logic                 o_frame_start
);

    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int DIVW        = clog2_min1(CLK_DIV);
    localparam int KIW         = clog2_min1(NUM_NOTES);
    localparam int PITCH       = KEY_W + KEY_GAP;
    localparam int KOW         = clog2_min1(PITCH);
    localparam int FCW         = clog2_min1(FADE_FRAMES);
    // Tracker is armed on the pixel just left of key 0 so its state lines up with x.
    localparam int KEY_TRIG    = H_ACT_START + KEY_X0 - 1;
    localparam int ROW_TOP     = V_ACT_START + KEY_Y0;
    localparam int ROW_BOT     = V_ACT_START + KEY_Y0 + KEY_H;

    if (KEY_X0 + NUM_NOTES * (KEY_W + KEY_GAP) - KEY_GAP > H_ACTIVE) begin : g_bad_key_x
        $error("vga_note_display: key row does not fit in H_ACTIVE");
    end
    if (KEY_Y0 + KEY_H > V_ACTIVE) begin : g_bad_key_y
        $error("vga_note_display: key row does not fit in V_ACTIVE");
    end

    logic [DIVW-1:0] div_q, div_d;
    logic            pe;
    logic [HW-1:0]   x;
    logic [VW-1:0]   y;
    logic            hsync, vsync, active, frame_start;

    logic [NUM_NOTES-1:0]          note_q;
    logic                          upd_q;
    logic [NUM_NOTES-1:0][3:0]     lvl_q, lvl_d;
    logic [NUM_NOTES-1:0][FCW-1:0] fcnt_q, fcnt_d;

    logic            run_q, run_d;
    logic [KIW-1:0]  kidx_q, kidx_d;
    logic [KOW-1:0]  koff_q, koff_d;
    logic            row_hit, key_hit;
    logic [3:0]      lvl_sel;

    rgb_t            pix_d, pix_q;
    logic            hsync_q, vsync_q, active_q;

    // Pixel-enable divider: pe on the last clk of each CLK_DIV group.
    always_comb begin
        div_d = (div_q == DIVW'(CLK_DIV - 1)) ? '0 : div_q + DIVW'(1);
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    assign pe = (div_q == DIVW'(CLK_DIV - 1));

    vga_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_FP        (H_FP),
        .H_SYNC      (H_SYNC),
        .H_BP        (H_BP),
        .V_ACTIVE    (V_ACTIVE),
        .V_FP        (V_FP),
        .V_SYNC      (V_SYNC),
        .V_BP        (V_BP),
        .SYNC_ACTIVE (SYNC_ACTIVE),
        .HW          (HW),
        .VW          (VW)
    ) u_timing (
        .clk           (clk),
        .reset         (reset),
        .pe_i          (pe),
        .x_o           (x),
        .y_o           (y),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .active_o      (active),
        .frame_start_o (frame_start)
    );

    // Latch the note vector once per frame; levels follow one clk later from the latched copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            if (frame_start) note_q <= note;
            upd_q <= frame_start;
        end
    end

    // Per-key fade: held -> full, released -> step down every FADE_FRAMES frames, stop at 0.
    always_comb begin
        lvl_d  = lvl_q;
        fcnt_d = fcnt_q;
        if (upd_q) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                if (note_q[i]) begin
                    lvl_d[i]  = 4'hF;
                    fcnt_d[i] = '0;
                end else if (lvl_q[i] != 4'h0) begin
                    if (fcnt_q[i] == FCW'(FADE_FRAMES - 1)) begin
                        lvl_d[i]  = lvl_q[i] - 4'd1;
                        fcnt_d[i] = '0;
                    end else begin
                        fcnt_d[i] = fcnt_q[i] + FCW'(1);
                    end
                end
            end
        end
    end

    // Fade level and frame counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q  <= '0;
            fcnt_q <= '0;
        end else begin
            lvl_q  <= lvl_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Key tracker: walks key index/offset along the line so no divide by PITCH is needed.
    always_comb begin
        run_d  = run_q;
        kidx_d = kidx_q;
        koff_d = koff_q;
        if (pe) begin
            if (x == HW'(KEY_TRIG)) begin
                run_d  = 1'b1;
                kidx_d = '0;
                koff_d = '0;
            end else if (run_q) begin
                if (kidx_q == KIW'(NUM_NOTES - 1) && koff_q == KOW'(KEY_W - 1)) begin
                    run_d = 1'b0;
                end else if (koff_q == KOW'(PITCH - 1)) begin
                    koff_d = '0;
                    kidx_d = kidx_q + KIW'(1);
                end else begin
                    koff_d = koff_q + KOW'(1);
                end
            end
        end
    end

    // Key tracker registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            kidx_q <= '0;
            koff_q <= '0;
        end else begin
            run_q  <= run_d;
            kidx_q <= kidx_d;
            koff_q <= koff_d;
        end
    end

    assign row_hit = (int'(y) >= ROW_TOP) && (int'(y) < ROW_BOT);
    assign key_hit = run_q && (int'(koff_q) < KEY_W) && row_hit;
    assign lvl_sel = lvl_q[kidx_q];

    // Pixel colour: blank outside active, red by level on a lit key, grey on a dark key.
    always_comb begin
        pix_d = RGB_BLACK;
        if (active && key_hit) begin
            if (lvl_sel != 4'h0) begin
                pix_d.r = lvl_sel;
            end else begin
                pix_d = RGB_GREY;
            end
        end
    end

    // Output register: syncs, active and colour share one pe of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
            active_q <= 1'b0;
            pix_q    <= RGB_BLACK;
        end else if (pe) begin
            hsync_q  <= hsync;
            vsync_q  <= vsync;
            active_q <= active;
            pix_q    <= pix_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_active      = active_q;
    assign o_red         = pix_q.r;
    assign o_green       = pix_q.g;
    assign o_blue        = pix_q.b;
    assign o_frame_start = frame_start;

endmodule

// File: tb/tb_vga_note_display.sv
// Directed bench for vga_note_display on a scaled-down raster so many frames fit in budget.
module tb_vga_note_display;

    localparam int   NN  = 4;
    localparam int   CD  = 2;
    localparam int   HA  = 20, HFP = 2, HS = 4, HBP = 3;
    localparam int   VA  = 6,  VFP = 1, VS = 2, VBP = 2;
    localparam logic SA  = 1'b0;
    localparam int   KX0 = 2, KY0 = 3, KW = 3, KG = 1, KH = 2, FF = 4;
    localparam int   HT  = 29;              // 4+3+20+2
    localparam int   VT  = 11;              // 2+2+6+1
    localparam int   FRAME_CLK = 2 * HT * VT;  // 638

    logic          clk, reset;
    logic [NN-1:0] note;
    logic          o_hsync, o_vsync, o_active, o_frame_start;
    logic [3:0]    o_red, o_green, o_blue;
    logic [11:0]   rgb;

    int checks = 0;
    int errors = 0;
    int q;        // negedges since the last observed o_frame_start
    int waited;   // negedges spent in the last sync_frame

    assign rgb = {o_red, o_green, o_blue};

    vga_note_display #(
        .NUM_NOTES (NN), .CLK_DIV (CD),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_ACTIVE (SA),
        .KEY_X0 (KX0), .KEY_Y0 (KY0), .KEY_W (KW), .KEY_GAP (KG), .KEY_H (KH),
        .FADE_FRAMES (FF)
    ) dut (
        .clk (clk), .reset (reset), .note (note),
        .o_hsync (o_hsync), .o_vsync (o_vsync),
        .o_red (o_red), .o_green (o_green), .o_blue (o_blue),
        .o_active (o_active), .o_frame_start (o_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) for the next o_frame_start, sampled on negedges.
    task automatic sync_frame();
        bit found = 0;
        waited = 0;
        while (!found && waited < 2 * FRAME_CLK + 20) begin
            @(negedge clk);
            waited++;
            if (o_frame_start === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_start_timeout: no pulse after %0d clk, expected within %0d", waited, FRAME_CLK);
        end
        q = 0;
    endtask

    // Move to the negedge where the registered outputs show pixel (x,y) of the current frame.
    task automatic seek(input int x, input int y);
        int t;
        t = 2 * (y * HT + x) + 1;
        if (t > q) repeat (t - q) @(negedge clk);
        q = t;
    endtask

    task automatic test_reset();
        int qb;
        reset = 1'b1;
        note  = '0;
        repeat (3) @(negedge clk);
        checks++; if (o_hsync !== ~SA) begin errors++; $display("FAIL rst_hsync got %b exp %b", o_hsync, ~SA); end
        checks++; if (o_vsync !== ~SA) begin errors++; $display("FAIL rst_vsync got %b exp %b", o_vsync, ~SA); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL rst_rgb got %h exp 000", rgb); end
        checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL rst_active got %b exp 0", o_active); end
        checks++; if (o_frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got %b exp 0", o_frame_start); end
        reset = 1'b0;
        sync_frame();
        checks++; if (waited != 1) begin errors++; $display("FAIL first_fs_latency got %0d exp 1", waited); end
        @(negedge clk); q = 1;
        checks++; if (o_frame_start !== 1'b0) begin errors++; $display("FAIL fs_width got %b exp 0", o_frame_start); end
        checks++; if (o_hsync !== SA) begin errors++; $display("FAIL hsync_x0 got %b exp %b", o_hsync, SA); end
        seek(3, 0);
        checks++; if (o_hsync !== SA) begin errors++; $display("FAIL hsync_x3 got %b exp %b", o_hsync, SA); end
        seek(4, 0);
        checks++; if (o_hsync !== ~SA) begin errors++; $display("FAIL hsync_x4 got %b exp %b", o_hsync, ~SA); end
        seek(28, 0);
        checks++; if (o_hsync !== ~SA) begin errors++; $display("FAIL hsync_x28 got %b exp %b", o_hsync, ~SA); end
        seek(0, 1);
        checks++; if (o_hsync !== SA) begin errors++; $display("FAIL hsync_line2 got %b exp %b", o_hsync, SA); end
        checks++; if (o_vsync !== SA) begin errors++; $display("FAIL vsync_y1 got %b exp %b", o_vsync, SA); end
        seek(0, 2);
        checks++; if (o_vsync !== ~SA) begin errors++; $display("FAIL vsync_y2 got %b exp %b", o_vsync, ~SA); end
        qb = q;
        sync_frame();
        checks++; if (waited != FRAME_CLK - qb) begin errors++; $display("FAIL frame_len got %0d exp %0d", waited, FRAME_CLK - qb); end
    endtask

    task automatic test_active();
        int tx[7] = '{7, 6, 7, 26, 27, 7, 7};
        int ty[7] = '{3, 4, 4, 4,  4,  9, 10};
        bit ta[7] = '{0, 0, 1, 1,  0,  1, 0};
        for (int i = 0; i < 7; i++) begin
            seek(tx[i], ty[i]);
            checks++;
            if (o_active !== ta[i]) begin
                errors++;
                $display("FAIL active(%0d,%0d) got %b exp %b", tx[i], ty[i], o_active, ta[i]);
            end
        end
    endtask

    task automatic test_single_key();
        int          tx[10] = '{10, 8, 9, 11, 12, 13, 23, 24, 10, 10};
        int          ty[10] = '{6,  7, 7, 7,  7,  7,  7,  7,  8,  9};
        logic [11:0] tc[10] = '{12'h000, 12'h000, 12'hF00, 12'hF00, 12'h000,
                                12'h444, 12'h444, 12'h000, 12'hF00, 12'h000};
        note = 4'b0001;
        sync_frame();
        for (int i = 0; i < 10; i++) begin
            seek(tx[i], ty[i]);
            checks++;
            if (rgb !== tc[i]) begin
                errors++;
                $display("FAIL key0_rgb(%0d,%0d) got %h exp %h", tx[i], ty[i], rgb, tc[i]);
            end
        end
    endtask

    task automatic test_mid_frame();
        sync_frame();
        seek(0, 5);
        note = 4'b0011;
        seek(14, 7);
        checks++; if (rgb !== 12'h444) begin errors++; $display("FAIL midframe_same got %h exp 444", rgb); end
        sync_frame();
        seek(10, 7);
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL midframe_key0 got %h exp F00", rgb); end
        seek(14, 7);
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL midframe_next got %h exp F00", rgb); end
    endtask

    task automatic test_fade();
        int          lvl;
        logic [11:0] exp_c;
        note = 4'b0001;
        for (int f = 0; f < 64; f++) begin
            sync_frame();
            seek(14, 7);
            lvl = 15 - (f + 1) / 4;
            if (lvl < 0) lvl = 0;
            exp_c = (lvl > 0) ? {lvl[3:0], 8'h00} : 12'h444;
            checks++;
            if (rgb !== exp_c) begin
                errors++;
                $display("FAIL fade_f%0d got %h exp %h", f, rgb, exp_c);
            end
        end
    endtask

    task automatic test_all_keys();
        int          tx[12] = '{10, 3, 10, 12, 14, 16, 18, 20, 22, 24, 27, 10};
        int          ty[12] = '{3,  7, 7,  7,  7,  7,  7,  7,  7,  7,  7,  10};
        logic [11:0] tc[12] = '{12'h000, 12'h000, 12'hF00, 12'h000, 12'hF00, 12'h000,
                                12'hF00, 12'h000, 12'hF00, 12'h000, 12'h000, 12'h000};
        bit          ta[12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        note = 4'hF;
        sync_frame();
        for (int i = 0; i < 12; i++) begin
            seek(tx[i], ty[i]);
            checks++;
            if (rgb !== tc[i]) begin
                errors++;
                $display("FAIL allkeys_rgb(%0d,%0d) got %h exp %h", tx[i], ty[i], rgb, tc[i]);
            end
            checks++;
            if (o_active !== ta[i]) begin
                errors++;
                $display("FAIL allkeys_active(%0d,%0d) got %b exp %b", tx[i], ty[i], o_active, ta[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        sync_frame();
        seek(22, 7);
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL pre_reset_key3 got %h exp F00", rgb); end
        seek(0, 8);
        note  = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o_hsync !== ~SA) begin errors++; $display("FAIL midrst_hsync got %b exp %b", o_hsync, ~SA); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL midrst_rgb got %h exp 000", rgb); end
        checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL midrst_active got %b exp 0", o_active); end
        reset = 1'b0;
        sync_frame();
        checks++; if (waited != 1) begin errors++; $display("FAIL midrst_fs_latency got %0d exp 1", waited); end
        seek(10, 7);
        checks++; if (rgb !== 12'h444) begin errors++; $display("FAIL midrst_key0 got %h exp 444", rgb); end
        seek(22, 7);
        checks++; if (rgb !== 12'h444) begin errors++; $display("FAIL midrst_key3 got %h exp 444", rgb); end
    endtask

    initial begin
        reset = 1'b1;
        note  = '0;
        q     = 0;
        test_reset();
        test_active();
        test_single_key();
        test_mid_frame();
        test_fade();
        test_all_keys();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
